forwarding_scoreboard: RTL and testbench

Parametrised register-hazard tracker that generalises the decode stage's per-operand forwarders. It holds its own shift register of in-flight destination registers, one slot per pipeline stage after decode, and captures each result as soon as any stage produces it. It serves `NUM_READ` read ports with forwarded data or a stall, and keeps a saturating stall-cycle counter. It sits beside the register file, is fed by decode on issue and by later stages on result production, and replaces the per-operand `forwarder` instances.

---
 rtl/forwarding_scoreboard.sv | 119 +++++++++++
 tb/tb_forwarding_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// Register-hazard tracker: shifts in-flight destination registers alongside the pipeline,
// captures results as stages produce them, and forwards or stalls each read port.
module forwarding_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         advance,
    input  logic                         issue_valid,
    input  logic                         issue_we,
    input  logic [ADDR_W-1:0]            issue_rd,
    input  logic [DEPTH-1:0]             flush_mask,
    input  logic [DEPTH-1:0]             result_valid,
    input  logic [DEPTH*DATA_W-1:0]      result_data,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_READ*DATA_W-1:0]   rf_data,
    output logic [NUM_READ*DATA_W-1:0]   fwd_data,
    output logic [NUM_READ-1:0]          fwd_hit,
    output logic [NUM_READ-1:0]          fwd_stall,
    output logic                         any_stall,
    output logic [CNT_W-1:0]             stall_cycles
);

    logic [DEPTH-1:0]  slot_v;
    logic [DEPTH-1:0]  slot_dv;
    logic [ADDR_W-1:0] slot_rd   [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];

    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  next_dv;
    logic [DATA_W-1:0] next_data [DEPTH];
    logic              issue_ok;

    assign issue_ok = issue_valid & issue_we & (issue_rd != '0);

    // Flush first, then capture; a killed slot ignores its result and carries nothing forward.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i]      = slot_v[i] & ~flush_mask[i];
            next_dv[i]   = live[i] & (slot_dv[i] | result_valid[i]);
            next_data[i] = (live[i] & result_valid[i] & ~slot_dv[i])
                           ? result_data[i*DATA_W +: DATA_W] : slot_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_v[i]    <= 1'b0;
                slot_dv[i]   <= 1'b0;
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else if (advance) begin
            slot_v[0]    <= issue_ok;
            slot_dv[0]   <= 1'b0;
            slot_rd[0]   <= issue_rd;
            slot_data[0] <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                slot_v[i]    <= live[i-1];
                slot_dv[i]   <= next_dv[i-1];
                slot_rd[i]   <= slot_rd[i-1];
                slot_data[i] <= next_data[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_v[i]    <= live[i];
                slot_dv[i]   <= next_dv[i];
                slot_data[i] <= next_data[i];
            end
        end
    end

    // Scan oldest to youngest so the lowest-index match overrides; an unknown winner stalls
    // even when an older slot already holds data.
    always_comb begin
        logic              found;
        logic              known;
        logic [DATA_W-1:0] win_data;
        logic [ADDR_W-1:0] addr;
        fwd_data  = rf_data;
        fwd_hit   = '0;
        fwd_stall = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            found    = 1'b0;
            known    = 1'b0;
            win_data = '0;
            addr     = rd_addr[p*ADDR_W +: ADDR_W];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (slot_v[i] && slot_rd[i] == addr && addr != '0) begin
                    found    = 1'b1;
                    known    = slot_dv[i] | result_valid[i];
                    win_data = result_valid[i] ? result_data[i*DATA_W +: DATA_W] : slot_data[i];
                end
            end
            if (found && known) begin
                fwd_hit[p]                    = 1'b1;
                fwd_data[p*DATA_W +: DATA_W]  = win_data;
            end else if (found) begin
                fwd_stall[p] = 1'b1;
            end
        end
    end

    assign any_stall = |fwd_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (any_stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: expected port results are queued as each step
// is driven and popped when the combinational outputs are sampled.
module tb_forwarding_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DP = 3;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             advance;
    logic             issue_valid;
    logic             issue_we;
    logic [AW-1:0]    issue_rd;
    logic [DP-1:0]    flush_mask;
    logic [DP-1:0]    result_valid;
    logic [DP*DW-1:0] result_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rf_data;
    logic [NR*DW-1:0] fwd_data;
    logic [NR-1:0]    fwd_hit;
    logic [NR-1:0]    fwd_stall;
    logic             any_stall;
    logic [CW-1:0]    stall_cycles;

    typedef struct {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    hit;
        logic [NR-1:0]    stall;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    forwarding_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .DEPTH(DP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .advance(advance), .issue_valid(issue_valid),
        .issue_we(issue_we), .issue_rd(issue_rd), .flush_mask(flush_mask),
        .result_valid(result_valid), .result_data(result_data), .rd_addr(rd_addr),
        .rf_data(rf_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit), .fwd_stall(fwd_stall),
        .any_stall(any_stall), .stall_cycles(stall_cycles)
    );

    task automatic cmp(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s/%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [NR-1:0] hit, input logic [NR-1:0] stall);
        exp_t e;
        e.data  = {d1, d0};
        e.hit   = hit;
        e.stall = stall;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        tag_q.push_back(tag);
        if (|stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        #1;
        e   = sb.pop_front();
        tag = tag_q.pop_front();
        cmp(tag, "fwd_data", 64'(fwd_data), 64'(e.data));
        cmp(tag, "fwd_hit", 64'(fwd_hit), 64'(e.hit));
        cmp(tag, "fwd_stall", 64'(fwd_stall), 64'(e.stall));
        cmp(tag, "any_stall", 64'(any_stall), 64'(|e.stall));
        cmp(tag, "stall_cycles", 64'(stall_cycles), 64'(e.cnt));
    endtask

    task automatic step(input string tag, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [NR-1:0] hit, input logic [NR-1:0] stall);
        applyStimulus(tag, d0, d1, hit, stall);
        checkOutput();
        @(negedge clk);
    endtask

    task automatic clearPulses();
        advance      = 1'b0;
        issue_valid  = 1'b0;
        issue_we     = 1'b0;
        issue_rd     = '0;
        flush_mask   = '0;
        result_valid = '0;
        rd_addr      = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        advance     = 1'b1;
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic setRd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic setRes(input int slot, input logic [DW-1:0] val);
        result_data[slot*DW +: DW] = val;
    endtask

    initial begin
        rst_n       = 1'b0;
        clearPulses();
        result_data = '0;
        rf_data     = {32'h22, 32'h11};

        setRd(5, 5);
        applyStimulus("reset", 32'h11, 32'h22, 2'b00, 2'b00);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Forward from slot 0 and keep forwarding as the entry ages to slot 2
        clearPulses(); issue(5); setRd(5, 0);
        step("A_issue_invisible", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); result_valid = 3'b001; setRes(0, 32'hDEADBEEF); setRd(5, 0);
        step("A_fwd_slot0", 32'hDEADBEEF, 32'h22, 2'b01, 2'b00);
        clearPulses(); advance = 1'b1; setRd(5, 0);
        step("A_held_slot0", 32'hDEADBEEF, 32'h22, 2'b01, 2'b00);
        clearPulses(); advance = 1'b1; setRd(5, 0);
        step("A_slot1", 32'hDEADBEEF, 32'h22, 2'b01, 2'b00);
        clearPulses(); setRd(5, 0);
        step("A_slot2", 32'hDEADBEEF, 32'h22, 2'b01, 2'b00);
        clearPulses(); advance = 1'b1; setRd(5, 0);
        step("A_slot2_retiring", 32'hDEADBEEF, 32'h22, 2'b01, 2'b00);
        clearPulses(); setRd(5, 0);
        step("A_retired", 32'h11, 32'h22, 2'b00, 2'b00);

        // Load-use stall on port 1, resolved by slot 1 result
        clearPulses(); issue(7); setRd(0, 7);
        step("B_issue_same_addr", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); advance = 1'b1; setRd(0, 1);
        step("B_move", 32'h11, 32'h22, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            clearPulses(); setRd(0, 7);
            step("B_stall", 32'h11, 32'h22, 2'b00, 2'b10);
        end
        clearPulses(); result_valid = 3'b010; setRes(1, 32'h42); setRd(0, 7);
        step("B_resolve", 32'h11, 32'h42, 2'b10, 2'b00);
        for (int k = 0; k < 2; k++) begin
            clearPulses(); advance = 1'b1;
            step("B_drain", 32'h11, 32'h22, 2'b00, 2'b00);
        end

        // Youngest unknown x3 must stall even though an older x3 is known
        clearPulses(); issue(3);
        step("C_issue_old", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); advance = 1'b1; result_valid = 3'b001; setRes(0, 32'hAAAA); setRd(3, 0);
        step("C_fwd_old", 32'hAAAA, 32'h22, 2'b01, 2'b00);
        clearPulses(); issue(3); setRd(3, 0);
        step("C_old_slot1", 32'hAAAA, 32'h22, 2'b01, 2'b00);
        clearPulses(); setRd(3, 3);
        step("C_young_stall", 32'h11, 32'h22, 2'b00, 2'b11);
        clearPulses(); result_valid = 3'b001; setRes(0, 32'hBBBB); setRd(3, 3);
        step("C_young_fwd", 32'hBBBB, 32'hBBBB, 2'b11, 2'b00);
        clearPulses(); setRd(3, 0);
        step("C_young_held", 32'hBBBB, 32'h22, 2'b01, 2'b00);
        for (int k = 0; k < 3; k++) begin
            clearPulses(); advance = 1'b1;
            step("C_drain", 32'h11, 32'h22, 2'b00, 2'b00);
        end

        // Flush while holding and while shifting; x0 and non-writing issues are never tracked
        clearPulses(); issue(9);
        step("D_issue", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); flush_mask = 3'b001; result_valid = 3'b001; setRes(0, 32'h99);
        step("D_flush_hold", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); setRd(9, 9);
        step("D_flushed", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); issue(9);
        step("D_issue2", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); advance = 1'b1; flush_mask = 3'b001; result_valid = 3'b001;
        setRes(0, 32'h99);
        step("D_flush_shift", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); setRd(9, 9);
        step("D_not_propagated", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); issue(0);
        step("D_issue_x0", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); setRd(0, 0);
        step("D_read_x0", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); issue(6); issue_we = 1'b0;
        step("D_issue_no_we", 32'h11, 32'h22, 2'b00, 2'b00);
        clearPulses(); setRd(6, 6);
        step("D_read_no_we", 32'h11, 32'h22, 2'b00, 2'b00);

        // Counter saturation at 4'hF
        clearPulses(); issue(12);
        step("E_issue", 32'h11, 32'h22, 2'b00, 2'b00);
        for (int k = 0; k < 20; k++) begin
            clearPulses(); setRd(12, 0);
            step("E_sat", 32'h11, 32'h22, 2'b00, 2'b01);
        end
        clearPulses(); setRd(12, 0);
        checks++;
        assert (stall_cycles === 4'hF) else begin
            errors++;
            $error("[TB] FAIL E_saturated observed=%h expected=%h", stall_cycles, 4'hF);
        end

        // Asynchronous reset in the middle of a stall
        exp_cnt = '0;
        applyStimulus("F_mid_reset", 32'h11, 32'h22, 2'b00, 2'b00);
        rst_n = 1'b0;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        clearPulses(); setRd(12, 12);
        step("F_after_reset", 32'h11, 32'h22, 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
